// File: rtl/cpu_step_ctrl_if.sv
// Board-side signal bundle for the CPU clock sequencer: button/switch/breakpoint
// inputs toward the controller, CPU clock and status back out.
interface cpu_step_ctrl_if;
  logic        button;
  logic        run_sw;
  logic [31:0] cur_pc;
  logic [31:0] bp_addr;
  logic        bp_valid;
  logic        cpu_clk;
  logic [15:0] step_count;
  logic        busy;
  logic        halted;

  modport master (
    output button, run_sw, cur_pc, bp_addr, bp_valid,
    input  cpu_clk, step_count, busy, halted
  );

  modport slave (
    input  button, run_sw, cur_pc, bp_addr, bp_valid,
    output cpu_clk, step_count, busy, halted
  );
endinterface

// File: rtl/cpu_step_ctrl.sv
// CPU clock sequencer: debounced single-step pulses or divided free-run clock.
// Optional PC breakpoint halt is built when CPU_STEP_BREAKPOINT_EN is defined.
//
//   state    | meaning
//   ---------+-----------------------------------------------------
//   IDLE     | step mode, waiting for a press or run_sw
//   DEBOUNCE | button high, counting consecutive high samples
//   FIRE     | cpu_clk high for PULSE_W cycles
//   WAIT_REL | step issued, waiting for button release
//   RUN      | free-run, counting low time before next pulse
//   HALT     | run mode stopped at breakpoint, waiting for a press
module cpu_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int RUN_DIV         = 25_000_000,
  parameter int PULSE_W         = 4
) (
  input  logic           CLK,
  input  logic           Reset,
  cpu_step_ctrl_if.slave bus
);
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DIV_W = $clog2(RUN_DIV + 1);
  localparam int PW_W  = $clog2(PULSE_W + 1);

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);
  localparam logic [PW_W-1:0]  PW_LAST  = PW_W'(PULSE_W);

  typedef enum logic [2:0] {IDLE, DEBOUNCE, FIRE, WAIT_REL, RUN, HALT} state_t;

  state_t           state;
  logic [DB_W-1:0]  db_cnt;
  logic [DB_W-1:0]  hdb_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic [PW_W-1:0]  pulse_cnt;
  logic             from_run;

`ifndef CPU_STEP_BREAKPOINT_EN
  logic unused_bp;
  assign unused_bp = ^{bus.cur_pc, bus.bp_addr, bus.bp_valid};
`endif

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state          <= IDLE;
      db_cnt         <= '0;
      hdb_cnt        <= '0;
      div_cnt        <= '0;
      pulse_cnt      <= '0;
      from_run       <= 1'b0;
      bus.cpu_clk    <= 1'b0;
      bus.step_count <= '0;
      bus.busy       <= 1'b0;
      bus.halted     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.run_sw) begin
            state    <= RUN;
            div_cnt  <= '0;
            bus.busy <= 1'b1;
          end else if (bus.button) begin
            state    <= DEBOUNCE;
            db_cnt   <= DB_W'(1);
            bus.busy <= 1'b1;
          end
        end
        DEBOUNCE: begin
          if (!bus.button) begin
            state    <= IDLE;
            db_cnt   <= '0;
            bus.busy <= 1'b0;
          end else if (db_cnt == DB_LAST) begin
            state       <= FIRE;
            db_cnt      <= '0;
            pulse_cnt   <= PW_W'(1);
            from_run    <= 1'b0;
            bus.cpu_clk <= 1'b1;
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end
        FIRE: begin
          if (pulse_cnt == PW_LAST) begin
            bus.cpu_clk    <= 1'b0;
            pulse_cnt      <= '0;
            bus.step_count <= bus.step_count + 16'd1;
            if (from_run) begin
`ifdef CPU_STEP_BREAKPOINT_EN
              // cur_pc already reflects the pulse that just ended
              if (bus.bp_valid && (bus.cur_pc == bus.bp_addr)) begin
                state      <= HALT;
                hdb_cnt    <= '0;
                bus.halted <= 1'b1;
              end else
`endif
              begin
                state   <= RUN;
                div_cnt <= '0;
              end
            end else begin
              state <= WAIT_REL;
            end
          end else begin
            pulse_cnt <= pulse_cnt + PW_W'(1);
          end
        end
        WAIT_REL: begin
          if (!bus.button) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        RUN: begin
          if (!bus.run_sw) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bus.busy <= 1'b0;
          end else if (div_cnt == DIV_LAST) begin
            state       <= FIRE;
            div_cnt     <= '0;
            pulse_cnt   <= PW_W'(1);
            from_run    <= 1'b1;
            bus.cpu_clk <= 1'b1;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        HALT: begin
          if (!bus.run_sw) begin
            state      <= IDLE;
            hdb_cnt    <= '0;
            bus.halted <= 1'b0;
            bus.busy   <= 1'b0;
          end else if (!bus.button) begin
            hdb_cnt <= '0;
          end else if (hdb_cnt == DB_LAST) begin
            // resume goes through WAIT_REL so a held button cannot re-trigger
            state      <= WAIT_REL;
            hdb_cnt    <= '0;
            bus.halted <= 1'b0;
          end else begin
            hdb_cnt <= hdb_cnt + DB_W'(1);
          end
        end
        default: begin
          state       <= IDLE;
          bus.cpu_clk <= 1'b0;
          bus.busy    <= 1'b0;
          bus.halted  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl with DEBOUNCE_CYCLES=4, RUN_DIV=5, PULSE_W=2.
// A tiny CPU model advances cur_pc by 4 on every cpu_clk rising edge.
module tb_cpu_step_ctrl;
  logic CLK = 1'b0;
  logic Reset;
  int   n_checks = 0;
  int   n_errors = 0;
  int   rise_cnt = 0;
  int   pc_base  = 0;

  cpu_step_ctrl_if bus ();

  cpu_step_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .RUN_DIV        (5),
    .PULSE_W        (2)
  ) dut (
    .CLK  (CLK),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  always @(posedge bus.cpu_clk) rise_cnt++;

  assign bus.cur_pc = 32'(rise_cnt - pc_base) << 2;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    Reset       = 1'b1;
    bus.button  = 1'b0;
    bus.run_sw  = 1'b0;
    tick();
    Reset = 1'b0;
  endtask

  initial begin
    logic [11:0] step_pat;
    logic [27:0] run_pat;
    int          r0;
    bit          seen;

    bus.bp_addr  = 32'h0;
    bus.bp_valid = 1'b0;
    do_reset();
    check_val("rst_cpu_clk", 32'(bus.cpu_clk), 32'd0);
    check_val("rst_step_count", 32'(bus.step_count), 32'd0);
    check_val("rst_busy", 32'(bus.busy), 32'd0);
    check_val("rst_halted", 32'(bus.halted), 32'd0);

    // step press: 12 high samples, pulse after edges 4 and 5
    bus.button = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      step_pat[i] = bus.cpu_clk;
    end
    check_val("step_pattern", 32'(step_pat), 32'h018);
    check_val("step_busy_held", 32'(bus.busy), 32'd1);
    check_val("step_count_1", 32'(bus.step_count), 32'd1);
    bus.button = 1'b0;
    tick();
    check_val("step_busy_release", 32'(bus.busy), 32'd0);

    // glitches shorter than the debounce window
    do_reset();
    r0 = rise_cnt;
    for (int g = 0; g < 2; g++) begin
      bus.button = 1'b1;
      tick(); tick(); tick();
      check_val("glitch_busy_mid", 32'(bus.busy), 32'd1);
      bus.button = 1'b0;
      tick();
    end
    repeat (6) tick();
    check_val("glitch_no_pulse", 32'(rise_cnt - r0), 32'd0);
    check_val("glitch_step_count", 32'(bus.step_count), 32'd0);
    check_val("glitch_idle", 32'(bus.busy), 32'd0);

    // run mode, button toggling ignored; rises after edges 6,13,20,27
    do_reset();
    bus.run_sw = 1'b1;
    for (int i = 0; i < 28; i++) begin
      bus.button = i[0];
      tick();
      run_pat[i] = bus.cpu_clk;
    end
    check_val("run_pattern", 32'(run_pat), 32'h0C18_3060);
    bus.run_sw = 1'b0;
    bus.button = 1'b0;
    tick();
    check_val("run_last_fall", 32'(bus.cpu_clk), 32'd0);
    check_val("run_step_count", 32'(bus.step_count), 32'd4);
    tick();
    check_val("run_off_idle", 32'(bus.busy), 32'd0);
    r0 = rise_cnt;
    repeat (10) tick();
    check_val("run_off_no_pulse", 32'(rise_cnt - r0), 32'd0);

    // run_sw dropped during first high cycle of a pulse
    do_reset();
    bus.run_sw = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = bus.cpu_clk;
    end
    check_val("stop_pulse_seen", 32'(seen), 32'd1);
    bus.run_sw = 1'b0;
    tick();
    check_val("stop_pulse_held", 32'(bus.cpu_clk), 32'd1);
    tick();
    check_val("stop_pulse_fall", 32'(bus.cpu_clk), 32'd0);
    check_val("stop_step_count", 32'(bus.step_count), 32'd1);
    tick();
    check_val("stop_idle", 32'(bus.busy), 32'd0);
    r0 = rise_cnt;
    repeat (15) tick();
    check_val("stop_no_pulse", 32'(rise_cnt - r0), 32'd0);

    // reset on the second high cycle of a step pulse
    do_reset();
    bus.button = 1'b1;
    repeat (4) tick();
    check_val("rstfire_first_high", 32'(bus.cpu_clk), 32'd1);
    tick();
    check_val("rstfire_second_high", 32'(bus.cpu_clk), 32'd1);
    Reset = 1'b1;
    tick();
    check_val("rstfire_cpu_clk", 32'(bus.cpu_clk), 32'd0);
    check_val("rstfire_step_count", 32'(bus.step_count), 32'd0);
    check_val("rstfire_busy", 32'(bus.busy), 32'd0);
    Reset = 1'b0;
    bus.button = 1'b0;
    tick();

    // breakpoint at PC 0x8 (reached at the end of the second run pulse)
    do_reset();
    pc_base      = rise_cnt;
    bus.bp_valid = 1'b1;
    bus.bp_addr  = 32'h0000_0008;
    r0 = rise_cnt;
    bus.run_sw = 1'b1;
    repeat (40) tick();
`ifdef CPU_STEP_BREAKPOINT_EN
    check_val("bp_pulses_before_halt", 32'(rise_cnt - r0), 32'd2);
    check_val("bp_halted", 32'(bus.halted), 32'd1);
    check_val("bp_pc", bus.cur_pc, 32'h8);
    repeat (50) tick();
    check_val("bp_no_pulse_50", 32'(rise_cnt - r0), 32'd2);
    check_val("bp_still_halted", 32'(bus.halted), 32'd1);
    bus.button = 1'b1;
    repeat (4) tick();
    check_val("bp_resume_halted", 32'(bus.halted), 32'd0);
    bus.button = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      tick();
      seen = bus.cpu_clk;
    end
    check_val("bp_resume_pulse", 32'(seen), 32'd1);
    check_val("bp_pc_moved", bus.cur_pc, 32'hC);
    repeat (3) tick();
    check_val("bp_no_rehalt", 32'(bus.halted), 32'd0);
    check_val("bp_step_count", 32'(bus.step_count), 32'd3);
`else
    check_val("nobp_pulses", 32'(rise_cnt - r0), 32'd5);
    check_val("nobp_halted", 32'(bus.halted), 32'd0);
    check_val("nobp_step_count", 32'(bus.step_count), 32'd5);
`endif
    bus.run_sw = 1'b0;
    repeat (4) tick();
    check_val("final_idle", 32'(bus.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
